mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter sharing the single-port instruction/data memory between the CPU (master 0) and a second bus master (master 1, e.g. a DMA or I/O engine). It accepts one access at a time, drives the memory command, address and write-data lines, and returns read data to the owning master. Contention is resolved round-robin. The block sits between the masters and the RAM and owns the memory's `mem_cmd`/`mem_addr`/`write_data` pins.

## Interface

Parameters:
- `AW`, 9, memory address width
- `DW`, 16, memory data width

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request from master 0 / master 1
- `m0_cmd`, `m1_cmd`  in  2  request command: 2'b01 = MREAD, 2'b10 = MWRITE
- `m0_addr`, `m1_addr`  in  AW  request address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse: request captured
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse: `rdata` holds this master's read result
- `rdata`  out  DW  registered read data, shared by both masters
- `mem_cmd`  out  2  memory command: 00 none, 01 MREAD, 10 MWRITE
- `mem_addr`  out  AW  memory address
- `write_data`  out  DW  memory write data
- `read_data`  in  DW  memory read data; valid the cycle after MREAD is presented

## Operation

- States: IDLE, ACCESS, RDATA.
- A request is valid when `mX_req`=1 and `mX_cmd` is 01 or 10. Commands 00 and 11 are ignored: no grant and no state change.
- IDLE:
  - With no valid request, remain in IDLE.
  - With exactly one valid request, that master wins.
  - With two valid requests, the master other than `last` wins.
  - On the winning edge:
    - Latch the winner's cmd, addr and wdata into `mem_cmd`, `mem_addr` and `write_data`.
    - Set the winner's `gnt`.
    - Set `last` to the winner and `owner` to the winner.
    - Go to ACCESS.
- ACCESS:
  - The memory sees the latched command for exactly one cycle.
  - On exit, `mem_cmd` returns to 00 and `gnt` clears.
  - If MWRITE, go to IDLE.
  - If MREAD, go to RDATA.
- RDATA:
  - `mem_cmd` is 00.
  - On exit, register `read_data` into `rdata`, pulse `mX_rvalid` for `owner`, and go to IDLE.
- Master obligations:
  - A master holds req/cmd/addr/wdata stable until it sees its `gnt`.
  - In the cycle after `gnt`, the master drops `req` or presents its next request. Any `req` still high when IDLE samples it is a new request.
- `mem_addr` and `write_data` hold their last values when `mem_cmd`=00.
- `rdata` holds its value until the next read completes.
- Reset (asynchronous, at any time, including mid-access):
  - State goes to IDLE and `last` goes to 1, so master 0 wins the first tie.
  - `mem_cmd`=00, `mem_addr`=0, `write_data`=0, `rdata`=0.
  - All `gnt` and `rvalid` go to 0.
  - An access interrupted by reset is dropped and no `rvalid` is issued for it.

## Timing

- All outputs are registered. There are no combinational paths from inputs to outputs.
- Read from IDLE, request sampled at the edge ending cycle N:
  - N+1: `gnt`=1 and `mem_cmd`=01.
  - N+2: `read_data` valid and `mem_cmd`=00.
  - N+3: `rvalid`=1, `rdata` valid, state IDLE.
  - Next grant no earlier than N+4.
- Write from IDLE, request sampled at the edge ending cycle N:
  - N+1: `gnt`=1 and `mem_cmd`=10.
  - N+2: IDLE.
  - Next grant no earlier than N+3.
- Requests arriving during ACCESS or RDATA wait. They are sampled only in IDLE.
- Under continuous contention, grants strictly alternate between the two masters.
- The `gnt` pulse is exactly 1 cycle. The `rvalid` pulse is exactly 1 cycle and asserts only for the reading master.
- At most one of `m0_gnt`/`m1_gnt` is high in any cycle. The same holds for `m0_rvalid`/`m1_rvalid`.

## Test plan

- **Master 0 read alone.** After reset, m0 MREAD at addr 9'h005 with memory word 16'hABCD.
  - `m0_gnt` at N+1 with `mem_cmd`=01 and `mem_addr`=005.
  - `m0_rvalid` at N+3 with `rdata`=16'hABCD.
  - `m1_gnt` and `m1_rvalid` stay 0 throughout.
- **Master 1 write alone.** m1 MWRITE addr 9'h1F0, wdata 16'h1234.
  - `m1_gnt` at N+1 with `mem_cmd`=10, `mem_addr`=1F0, `write_data`=1234.
  - `mem_cmd`=00 at N+2.
  - No `rvalid` pulse.
- **Simultaneous requests after reset.** Both masters request at once and hold the request across re-grants: m0 reads 010, m1 writes 020.
  - m0 is granted first because of the tie rule.
  - m1 is granted only after m0's `rvalid`, in the cycle following return to IDLE.
  - With both masters kept requesting, the grant order is 0,1,0,1.
- **Illegal and empty commands.** m0 `req` with cmd=11 for 5 cycles, then cmd=00.
  - No grant and `mem_cmd` stays 00.
  - A valid m1 request during this window is granted normally.
- **Reset mid-read.** Drop `reset` low during RDATA.
  - `mem_cmd`=00, all `gnt` and `rvalid`=0, `rdata`=0 immediately without a clock edge.
  - After release, a tie is again won by m0.
- **Request held too long.** m0 keeps `req` high with the same read for 2 cycles after `gnt`.
  - A second read to the same address is granted when the arbiter returns to IDLE.
  - Two `rvalid` pulses result.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets two bus masters share one
// single-port memory. One access is in flight at a time. The block drives the
// memory command/address/write-data pins and returns read data to the master
// that owns the access.
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous active-low reset
//   m0_req / m1_req      access request
//   m0_cmd / m1_cmd      2'b01 MREAD, 2'b10 MWRITE (00/11 ignored)
//   m0_addr / m1_addr    request address
//   m0_wdata / m1_wdata  request write data
//   m0_gnt / m1_gnt      1-cycle pulse, request captured
//   m0_rvalid/m1_rvalid  1-cycle pulse, rdata holds this master's read result
//   rdata                registered read data, shared
//   mem_cmd              memory command: 00 none, 01 MREAD, 10 MWRITE
//   mem_addr             memory address
//   write_data           memory write data
//   read_data            memory read data, valid the cycle after MREAD
module mem_arbiter #(
   parameter int unsigned AW = 9,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic [1:0]    m0_cmd,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m1_req,
   input  logic [1:0]    m1_cmd,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_gnt,
   output logic          m1_gnt,
   output logic          m0_rvalid,
   output logic          m1_rvalid,
   output logic [DW-1:0] rdata,
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] write_data,
   input  logic [DW-1:0] read_data
);

   localparam logic [1:0] CMD_NONE  = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RDATA  = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_last;     // master granted most recently
   logic          r_owner;    // master owning the access in flight
   logic [1:0]    r_mem_cmd;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_write_data;
   logic [DW-1:0] r_rdata;
   logic          r_m0_gnt;
   logic          r_m1_gnt;
   logic          r_m0_rvalid;
   logic          r_m1_rvalid;

   logic          w_m0_valid;
   logic          w_m1_valid;
   logic          w_any_valid;
   logic          w_pick1;
   logic [1:0]    w_win_cmd;
   logic [AW-1:0] w_win_addr;
   logic [DW-1:0] w_win_wdata;

   // Request qualification and round-robin winner selection
   always_comb begin
      w_m0_valid  = m0_req && ((m0_cmd == CMD_READ) || (m0_cmd == CMD_WRITE));
      w_m1_valid  = m1_req && ((m1_cmd == CMD_READ) || (m1_cmd == CMD_WRITE));
      w_any_valid = w_m0_valid || w_m1_valid;
      // On a tie, the master that was not granted last wins
      w_pick1     = w_m1_valid && (!w_m0_valid || !r_last);
      w_win_cmd   = w_pick1 ? m1_cmd   : m0_cmd;
      w_win_addr  = w_pick1 ? m1_addr  : m0_addr;
      w_win_wdata = w_pick1 ? m1_wdata : m0_wdata;
   end

   // Arbitration FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_last       <= 1'b1;
         r_owner      <= 1'b0;
         r_mem_cmd    <= CMD_NONE;
         r_mem_addr   <= '0;
         r_write_data <= '0;
         r_rdata      <= '0;
         r_m0_gnt     <= 1'b0;
         r_m1_gnt     <= 1'b0;
         r_m0_rvalid  <= 1'b0;
         r_m1_rvalid  <= 1'b0;
      end else begin
         r_m0_gnt    <= 1'b0;
         r_m1_gnt    <= 1'b0;
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_valid) begin
                  r_mem_cmd    <= w_win_cmd;
                  r_mem_addr   <= w_win_addr;
                  r_write_data <= w_win_wdata;
                  r_m0_gnt     <= !w_pick1;
                  r_m1_gnt     <= w_pick1;
                  r_last       <= w_pick1;
                  r_owner      <= w_pick1;
                  r_state      <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Command is presented to the memory for exactly this cycle
               r_mem_cmd <= CMD_NONE;
               r_state   <= (r_mem_cmd == CMD_READ) ? S_RDATA : S_IDLE;
            end
            S_RDATA: begin
               r_rdata     <= read_data;
               r_m0_rvalid <= !r_owner;
               r_m1_rvalid <= r_owner;
               r_state     <= S_IDLE;
            end
            default: begin
               r_mem_cmd <= CMD_NONE;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign m0_gnt     = r_m0_gnt;
   assign m1_gnt     = r_m1_gnt;
   assign m0_rvalid  = r_m0_rvalid;
   assign m1_rvalid  = r_m1_rvalid;
   assign rdata      = r_rdata;
   assign mem_cmd    = r_mem_cmd;
   assign mem_addr   = r_mem_addr;
   assign write_data = r_write_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          m0_req = 1'b0;
   logic [1:0]    m0_cmd = 2'b00;
   logic [AW-1:0] m0_addr = '0;
   logic [DW-1:0] m0_wdata = '0;
   logic          m1_req = 1'b0;
   logic [1:0]    m1_cmd = 2'b00;
   logic [AW-1:0] m1_addr = '0;
   logic [DW-1:0] m1_wdata = '0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] rdata;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] write_data;
   logic [DW-1:0] read_data = '0;

   int checks = 0;
   int errors = 0;

   // Bench-side RAM with a backdoor load port
   logic [DW-1:0] mem [512];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .rdata(rdata), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
      .read_data(read_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (mem_cmd == 2'b10) mem[mem_addr] <= write_data;
      if (mem_cmd == 2'b01) read_data <= mem[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic drop_all();
      m0_req = 1'b0; m0_cmd = 2'b00;
      m1_req = 1'b0; m1_cmd = 2'b00;
      repeat (4) tick();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      checks++; if (mem_cmd !== 2'b00) begin errors++; $display("FAIL reset_mem_cmd: got %0h want 0", mem_cmd); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
      checks++; if (write_data !== '0) begin errors++; $display("FAIL reset_write_data: got %0h want 0", write_data); end
      checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
      checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
         errors++; $display("FAIL reset_pulses: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_m0_read();
      logic other;
      mem_load(9'h005, 16'hABCD);
      other = 1'b0;
      m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h005;
      tick();  // N+1
      other |= m1_gnt | m1_rvalid;
      checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL m0_read_gnt: got %b want 1", m0_gnt); end
      checks++; if (mem_cmd !== 2'b01) begin errors++; $display("FAIL m0_read_cmd: got %0h want 1", mem_cmd); end
      checks++; if (mem_addr !== 9'h005) begin errors++; $display("FAIL m0_read_addr: got %0h want 005", mem_addr); end
      m0_req = 1'b0; m0_cmd = 2'b00;
      tick();  // N+2
      other |= m1_gnt | m1_rvalid;
      checks++; if ({mem_cmd, m0_gnt, m0_rvalid} !== 4'b0000) begin
         errors++; $display("FAIL m0_read_n2: got cmd=%0h gnt=%b rv=%b want 0/0/0", mem_cmd, m0_gnt, m0_rvalid); end
      tick();  // N+3
      other |= m1_gnt | m1_rvalid;
      checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL m0_read_rvalid: got %b want 1", m0_rvalid); end
      checks++; if (rdata !== 16'hABCD) begin errors++; $display("FAIL m0_read_rdata: got %0h want abcd", rdata); end
      tick();  // N+4
      other |= m1_gnt | m1_rvalid;
      checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL m0_read_rvalid_pulse: got %b want 0", m0_rvalid); end
      checks++; if (rdata !== 16'hABCD) begin errors++; $display("FAIL m0_read_rdata_hold: got %0h want abcd", rdata); end
      checks++; if (other !== 1'b0) begin errors++; $display("FAIL m0_read_m1_quiet: got %b want 0", other); end
   endtask

   task automatic test_m1_write();
      logic rv;
      rv = 1'b0;
      m1_req = 1'b1; m1_cmd = 2'b10; m1_addr = 9'h1F0; m1_wdata = 16'h1234;
      tick();  // N+1
      rv |= m0_rvalid | m1_rvalid;
      checks++; if ({m1_gnt, m0_gnt} !== 2'b10) begin errors++; $display("FAIL m1_write_gnt: got m1=%b m0=%b want 1/0", m1_gnt, m0_gnt); end
      checks++; if (mem_cmd !== 2'b10) begin errors++; $display("FAIL m1_write_cmd: got %0h want 2", mem_cmd); end
      checks++; if (mem_addr !== 9'h1F0) begin errors++; $display("FAIL m1_write_addr: got %0h want 1f0", mem_addr); end
      checks++; if (write_data !== 16'h1234) begin errors++; $display("FAIL m1_write_data: got %0h want 1234", write_data); end
      m1_req = 1'b0; m1_cmd = 2'b00;
      tick();  // N+2
      rv |= m0_rvalid | m1_rvalid;
      checks++; if ({mem_cmd, m1_gnt} !== 3'b000) begin errors++; $display("FAIL m1_write_n2: got cmd=%0h gnt=%b want 0/0", mem_cmd, m1_gnt); end
      checks++; if (write_data !== 16'h1234) begin errors++; $display("FAIL m1_write_hold: got %0h want 1234", write_data); end
      checks++; if (mem[9'h1F0] !== 16'h1234) begin errors++; $display("FAIL m1_write_mem: got %0h want 1234", mem[9'h1F0]); end
      repeat (3) begin tick(); rv |= m0_rvalid | m1_rvalid; end
      checks++; if (rv !== 1'b0) begin errors++; $display("FAIL m1_write_no_rvalid: got %b want 0", rv); end
   endtask

   task automatic test_simultaneous();
      int order[$];
      int rv0_cyc, g1_cyc;
      logic both;
      apply_reset();
      rv0_cyc = -1; g1_cyc = -1; both = 1'b0;
      m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h010;
      m1_req = 1'b1; m1_cmd = 2'b10; m1_addr = 9'h020; m1_wdata = 16'h5555;
      for (int c = 1; c <= 30 && order.size() < 4; c++) begin
         tick();
         both |= m0_gnt & m1_gnt;
         if (m0_gnt) order.push_back(0);
         if (m1_gnt) begin order.push_back(1); if (g1_cyc < 0) g1_cyc = c; end
         if (m0_rvalid && rv0_cyc < 0) rv0_cyc = c;
      end
      m0_req = 1'b0; m0_cmd = 2'b00; m1_req = 1'b0; m1_cmd = 2'b00;
      checks++; if (order.size() !== 4) begin errors++; $display("FAIL simul_grant_count: got %0d want 4 (cycle budget)", order.size()); end
      else begin
         checks++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
            errors++; $display("FAIL simul_order: got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]); end
      end
      checks++; if (rv0_cyc !== 3) begin errors++; $display("FAIL simul_rv0_cycle: got %0d want 3", rv0_cyc); end
      checks++; if (g1_cyc !== rv0_cyc + 1) begin errors++; $display("FAIL simul_g1_after_rv0: got %0d want %0d", g1_cyc, rv0_cyc + 1); end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL simul_onehot_gnt: got %b want 0", both); end
      drop_all();
   endtask

   task automatic test_illegal();
      logic bad;
      bad = 1'b0;
      m0_req = 1'b1; m0_cmd = 2'b11; m0_addr = 9'h033;
      repeat (5) begin tick(); bad |= m0_gnt | m1_gnt | (mem_cmd != 2'b00); end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL illegal_cmd11: got activity=%b want 0", bad); end
      m0_cmd = 2'b00;
      tick();
      bad |= m0_gnt | m1_gnt | (mem_cmd != 2'b00);
      m1_req = 1'b1; m1_cmd = 2'b10; m1_addr = 9'h0AA; m1_wdata = 16'hBEEF;
      tick();
      checks++; if ({m1_gnt, m0_gnt} !== 2'b10) begin errors++; $display("FAIL illegal_m1_gnt: got m1=%b m0=%b want 1/0", m1_gnt, m0_gnt); end
      checks++; if (mem_cmd !== 2'b10 || mem_addr !== 9'h0AA) begin
         errors++; $display("FAIL illegal_m1_cmd: got cmd=%0h addr=%0h want 2/0aa", mem_cmd, mem_addr); end
      m1_req = 1'b0; m1_cmd = 2'b00;
      repeat (3) begin tick(); bad |= m0_gnt | m1_gnt; end
      checks++; if (bad !== 1'b0) begin errors++; $display("FAIL illegal_cmd00: got activity=%b want 0", bad); end
      m0_req = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      mem_load(9'h030, 16'h5A5A);
      m1_req = 1'b1; m1_cmd = 2'b01; m1_addr = 9'h030;
      tick();
      m1_req = 1'b0; m1_cmd = 2'b00;
      repeat (4) tick();
      checks++; if (rdata !== 16'h5A5A) begin errors++; $display("FAIL rstmid_pre_rdata: got %0h want 5a5a", rdata); end
      m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h005;
      tick();  // N+1 gnt
      m0_req = 1'b0; m0_cmd = 2'b00;
      tick();  // N+2 RDATA
      #2 reset = 1'b0;
      #1;
      checks++; if (mem_cmd !== 2'b00 || rdata !== '0 || mem_addr !== '0 || write_data !== '0) begin
         errors++; $display("FAIL rstmid_async: got cmd=%0h rdata=%0h addr=%0h wd=%0h want 0", mem_cmd, rdata, mem_addr, write_data); end
      checks++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_pulses: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      checks++; if (m0_rvalid !== 1'b0 || rdata !== '0) begin errors++; $display("FAIL rstmid_dropped: got rv=%b rdata=%0h want 0/0", m0_rvalid, rdata); end
      m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h005;
      m1_req = 1'b1; m1_cmd = 2'b01; m1_addr = 9'h030;
      tick();
      checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rstmid_tie: got m0=%b m1=%b want 1/0", m0_gnt, m1_gnt); end
      m0_req = 1'b0; m0_cmd = 2'b00;
      repeat (3) tick();   // m1 still requesting, granted now
      m1_req = 1'b0; m1_cmd = 2'b00;
      repeat (4) tick();
   endtask

   task automatic test_held_too_long();
      int g, rv, g2_cyc;
      mem_load(9'h040, 16'h1357);
      g = 0; rv = 0; g2_cyc = -1;
      m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h040;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (m0_gnt) begin g++; if (g == 2) begin g2_cyc = c; m0_req = 1'b0; m0_cmd = 2'b00; end end
         if (m0_rvalid) rv++;
      end
      m0_req = 1'b0; m0_cmd = 2'b00;
      checks++; if (g !== 2) begin errors++; $display("FAIL held_gnt_count: got %0d want 2", g); end
      checks++; if (g2_cyc !== 4) begin errors++; $display("FAIL held_second_gnt_cycle: got %0d want 4", g2_cyc); end
      checks++; if (rv !== 2) begin errors++; $display("FAIL held_rvalid_count: got %0d want 2", rv); end
      checks++; if (rdata !== 16'h1357) begin errors++; $display("FAIL held_rdata: got %0h want 1357", rdata); end
   endtask

   // Randomized traffic against a transaction-level model
   task automatic test_random();
      logic [DW-1:0] ref_mem [16];
      logic          q_req [2];
      logic [1:0]    q_cmd [2];
      logic [AW-1:0] q_addr [2];
      logic [DW-1:0] q_wd [2];
      logic          v [2];
      logic          e_g [2];
      logic          e_rv [2];
      logic [1:0]    e_cmd;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_rdata, pend_data;
      int            busy, last, owner, win;
      logic          pend_read;

      drop_all();
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 16'($urandom);
         mem_load(9'(i), ref_mem[i]);
      end
      apply_reset();
      busy = 0; last = 1; owner = 0; pend_read = 1'b0; pend_data = '0;
      e_addr = '0; e_wd = '0; e_rdata = '0;
      for (int m = 0; m < 2; m++) begin q_req[m] = 1'b0; q_cmd[m] = 2'b00; q_addr[m] = '0; q_wd[m] = '0; end

      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int m = 0; m < 2; m++) begin
            if (!(q_req[m] && (q_cmd[m] == 2'b01 || q_cmd[m] == 2'b10))) begin
               q_req[m]  = ($urandom % 3) != 0;
               q_cmd[m]  = 2'($urandom % 4);
               q_addr[m] = 9'($urandom % 16);
               q_wd[m]   = 16'($urandom);
            end
         end
         m0_req = q_req[0]; m0_cmd = q_cmd[0]; m0_addr = q_addr[0]; m0_wdata = q_wd[0];
         m1_req = q_req[1]; m1_cmd = q_cmd[1]; m1_addr = q_addr[1]; m1_wdata = q_wd[1];

         // Expected outcome of the coming edge
         e_g[0] = 1'b0; e_g[1] = 1'b0; e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_cmd = 2'b00;
         if (busy > 0) begin
            busy--;
            if (busy == 0 && pend_read) begin
               e_rv[owner] = 1'b1; e_rdata = pend_data; pend_read = 1'b0;
            end
         end else begin
            for (int m = 0; m < 2; m++) v[m] = q_req[m] && (q_cmd[m] == 2'b01 || q_cmd[m] == 2'b10);
            if (v[0] && v[1]) win = 1 - last;
            else if (v[0])    win = 0;
            else if (v[1])    win = 1;
            else              win = -1;
            if (win >= 0) begin
               e_g[win] = 1'b1; e_cmd = q_cmd[win]; e_addr = q_addr[win]; e_wd = q_wd[win];
               last = win; owner = win;
               if (q_cmd[win] == 2'b01) begin
                  busy = 2; pend_read = 1'b1; pend_data = ref_mem[q_addr[win][3:0]];
               end else begin
                  busy = 1; ref_mem[q_addr[win][3:0]] = q_wd[win];
               end
            end
         end

         tick();

         checks++; if (m0_gnt !== e_g[0]) begin errors++; $display("FAIL rand_m0_gnt cyc %0d: got %b want %b", cyc, m0_gnt, e_g[0]); end
         checks++; if (m1_gnt !== e_g[1]) begin errors++; $display("FAIL rand_m1_gnt cyc %0d: got %b want %b", cyc, m1_gnt, e_g[1]); end
         checks++; if (m0_rvalid !== e_rv[0]) begin errors++; $display("FAIL rand_m0_rvalid cyc %0d: got %b want %b", cyc, m0_rvalid, e_rv[0]); end
         checks++; if (m1_rvalid !== e_rv[1]) begin errors++; $display("FAIL rand_m1_rvalid cyc %0d: got %b want %b", cyc, m1_rvalid, e_rv[1]); end
         checks++; if (mem_cmd !== e_cmd) begin errors++; $display("FAIL rand_mem_cmd cyc %0d: got %0h want %0h", cyc, mem_cmd, e_cmd); end
         checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rand_mem_addr cyc %0d: got %0h want %0h", cyc, mem_addr, e_addr); end
         checks++; if (write_data !== e_wd) begin errors++; $display("FAIL rand_write_data cyc %0d: got %0h want %0h", cyc, write_data, e_wd); end
         checks++; if (rdata !== e_rdata) begin errors++; $display("FAIL rand_rdata cyc %0d: got %0h want %0h", cyc, rdata, e_rdata); end

         // A granted master drops its request; it may re-request next cycle
         for (int m = 0; m < 2; m++) if (e_g[m]) q_req[m] = 1'b0;
      end
      drop_all();
   endtask

   initial begin
      test_reset();
      test_m0_read();
      test_m1_write();
      test_simultaneous();
      test_illegal();
      test_reset_mid_read();
      test_held_too_long();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
